// File: rtl/branch_predictor_if.sv
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Lookup, branch-resolution update and statistics signals
//                exchanged between the pipeline (IF/EX) and the predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_if;
    // Fetch-side lookup
    logic [31:0] if_pc;
    logic        predict_taken;
    logic [31:0] predict_npc;

    // EX-side resolution bundle
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    // Free-running statistics
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    // Pipeline side: drives lookups and resolutions, observes predictions
    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  predict_taken, predict_npc, stat_branches, stat_mispredicts
    );

    // Predictor side
    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output predict_taken, predict_npc, stat_branches, stat_mispredicts
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped 2-bit saturating counter predictor with a
//                tagged branch target buffer and branch/mispredict counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter int         TAG_W    = 24,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  wire               clk_in,
    input  wire               rst_in,
    input  wire               rdy_in,
    branch_predictor_if.slave bus
);
    localparam int         c_depth    = 1 << IDX_W;
    localparam logic [1:0] c_cnt_max  = 2'b11;
    localparam logic [1:0] c_cnt_min  = 2'b00;
    localparam logic [1:0] c_cnt_wt   = 2'b10;   // weakly taken
    localparam logic [1:0] c_cnt_wnt  = 2'b01;   // weakly not-taken

    // Per-entry storage
    logic [1:0]       r_cnt    [c_depth];
    logic             r_valid  [c_depth];
    logic [TAG_W-1:0] r_tag    [c_depth];
    logic [31:0]      r_target [c_depth];

    logic [31:0]      r_stat_branches;
    logic [31:0]      r_stat_mispredicts;

    // Lookup path
    logic [IDX_W-1:0] w_lidx;
    logic [TAG_W-1:0] w_ltag;
    logic             w_lhit;
    logic             w_ltaken;

    // Update path
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_alias;
    logic [1:0]       w_cnt_cur;
    logic [1:0]       w_cnt_next;
    logic             w_accept;

    // Byte-offset bits of the resolved PC carry no information for indexing
    logic             w_unused_pc_bits;
    assign w_unused_pc_bits = &{1'b0, bus.upd_pc[1:0]};

    assign w_lidx   = bus.if_pc[IDX_W+1:2];
    assign w_ltag   = bus.if_pc[31:IDX_W+2];
    assign w_lhit   = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign w_ltaken = w_lhit && r_cnt[w_lidx][1];

    assign bus.predict_taken    = w_ltaken;
    assign bus.predict_npc      = w_ltaken ? r_target[w_lidx] : bus.if_pc + 32'd4;
    assign bus.stat_branches    = r_stat_branches;
    assign bus.stat_mispredicts = r_stat_mispredicts;

    assign w_uidx    = bus.upd_pc[IDX_W+1:2];
    assign w_utag    = bus.upd_pc[31:IDX_W+2];
    assign w_alias   = r_valid[w_uidx] && (r_tag[w_uidx] != w_utag);
    assign w_cnt_cur = r_cnt[w_uidx];
    assign w_accept  = rdy_in && bus.upd_valid;

    // Next counter value: restart on a reallocated alias, otherwise saturate
    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_alias) begin
            w_cnt_next = bus.upd_taken ? c_cnt_wt : c_cnt_wnt;
        end else if (bus.upd_taken) begin
            if (w_cnt_cur != c_cnt_max) begin
                w_cnt_next = w_cnt_cur + 2'd1;
            end
        end else begin
            if (w_cnt_cur != c_cnt_min) begin
                w_cnt_next = w_cnt_cur - 2'd1;
            end
        end
    end

    // Table training; reset wipes everything and overrides a pending update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < c_depth; k++) begin
                r_cnt[k]    <= CNT_INIT;
                r_valid[k]  <= 1'b0;
                r_tag[k]    <= '0;
                r_target[k] <= '0;
            end
        end else if (w_accept) begin
            r_cnt[w_uidx] <= w_cnt_next;
            if (bus.upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bus.upd_target;
            end else if (w_alias) begin
                // A not-taken alias evicts the previous owner
                r_valid[w_uidx]  <= 1'b0;
            end
        end
    end

    // Statistics counters, frozen while the pipeline is stalled
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_accept) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (bus.upd_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed scenarios followed by random traffic, compared
//                against a behavioural model of the predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;
    localparam int IDX_W = 6;
    localparam int DEPTH = 64;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   checks   = 0;
    int   failures = 0;
    logic obs_taken;

    branch_predictor_if bus ();

    branch_predictor #(
        .IDX_W   (IDX_W),
        .TAG_W   (24),
        .CNT_INIT(2'b01)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model: plain integer tables
    int          m_cnt   [DEPTH];
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] npc);
        int i;
        i   = idx_of(pc);
        tk  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
        npc = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_update(input bit rst, input bit rdy, input bit uv, input logic [31:0] pc,
                                input bit tk, input logic [31:0] tgt, input bit mis);
        int  j;
        bit  owned_by_other;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_cnt[k] = 1; m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0;
            end
            m_br  = 0;
            m_mis = 0;
        end else if (rdy && uv) begin
            m_br++;
            if (mis) m_mis++;
            j = idx_of(pc);
            owned_by_other = m_valid[j] && (m_tag[j] != tag_of(pc));
            if (owned_by_other) m_cnt[j] = tk ? 2 : 1;
            else if (tk)        m_cnt[j] = (m_cnt[j] + 1 > 3) ? 3 : m_cnt[j] + 1;
            else                m_cnt[j] = (m_cnt[j] - 1 < 0) ? 0 : m_cnt[j] - 1;
            if (tk) begin
                m_valid[j] = 1; m_tag[j] = tag_of(pc); m_tgt[j] = tgt;
            end else if (owned_by_other) begin
                m_valid[j] = 0;
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic        etk;
        logic [31:0] enpc;
        model_predict(bus.if_pc, etk, enpc);
        check({tag, "_taken"}, {31'd0, bus.predict_taken}, {31'd0, etk});
        check({tag, "_npc"}, bus.predict_npc, enpc);
        check({tag, "_br"}, bus.stat_branches, m_br);
        check({tag, "_mis"}, bus.stat_mispredicts, m_mis);
    endtask

    // One clock: drive, check pre-edge outputs against the model, clock, train model
    task automatic step(input bit rst, input bit rdy, input bit uv, input logic [31:0] upc,
                        input bit tk, input logic [31:0] tgt, input bit mis, input logic [31:0] lpc);
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy;
        bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = tk;
        bus.upd_target = tgt; bus.upd_mispredict = mis; bus.if_pc = lpc;
        #1;
        obs_taken = bus.predict_taken;
        compare_outputs("step");
        @(posedge clk_in);
        model_update(rst, rdy, uv, upc, tk, tgt, mis);
    endtask

    // Idle lookup, left at the sample point so callers can add fixed checks
    task automatic look(input logic [31:0] pc);
        @(negedge clk_in);
        rst_in = 1'b0; rdy_in = 1'b1; bus.upd_valid = 1'b0; bus.if_pc = pc;
        #1;
        compare_outputs("look");
    endtask

    initial begin
        logic [31:0] tags [3];
        logic [31:0] upc, lpc;
        tags[0] = 32'h0000_0004; tags[1] = 32'h0000_0009; tags[2] = 32'h00AB_CDEF;

        rst_in = 1'b1; rdy_in = 1'b1;
        bus.if_pc = 32'h1000; bus.upd_valid = 1'b0; bus.upd_pc = '0;
        bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            m_cnt[k] = 1; m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0;
        end
        m_br = 0; m_mis = 0;
        @(posedge clk_in);

        // Reset defaults
        step(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        step(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        look(32'h1000);
        check("rst_taken", {31'd0, bus.predict_taken}, 32'd0);
        check("rst_npc", bus.predict_npc, 32'h1004);
        check("rst_br", bus.stat_branches, 32'd0);
        check("rst_mis", bus.stat_mispredicts, 32'd0);

        // Training
        step(0, 1, 1, 32'h1000, 1, 32'h0F00, 1, 32'h1000);
        look(32'h1000);
        check("train1_taken", {31'd0, bus.predict_taken}, 32'd1);
        check("train1_npc", bus.predict_npc, 32'h0F00);
        step(0, 1, 1, 32'h1000, 1, 32'h0F00, 1, 32'h1000);
        look(32'h1000);
        check("train2_br", bus.stat_branches, 32'd2);
        check("train2_mis", bus.stat_mispredicts, 32'd2);

        // Hysteresis and saturation at zero
        step(0, 1, 1, 32'h1000, 0, 0, 0, 32'h1000);
        look(32'h1000);
        check("hyst1_taken", {31'd0, bus.predict_taken}, 32'd1);
        step(0, 1, 1, 32'h1000, 0, 0, 0, 32'h1000);
        look(32'h1000);
        check("hyst2_taken", {31'd0, bus.predict_taken}, 32'd0);
        check("hyst2_npc", bus.predict_npc, 32'h1004);
        repeat (3) step(0, 1, 1, 32'h1000, 0, 0, 0, 32'h1000);
        step(0, 1, 1, 32'h1000, 1, 32'h0F00, 0, 32'h1000);
        look(32'h1000);
        check("sat0_taken", {31'd0, bus.predict_taken}, 32'd0);
        repeat (2) step(0, 1, 1, 32'h1000, 1, 32'h0F00, 0, 32'h1000);

        // Alias at index 0
        step(0, 1, 1, 32'h1100, 1, 32'h2000, 0, 32'h1100);
        look(32'h1100);
        check("alias_taken", {31'd0, bus.predict_taken}, 32'd1);
        check("alias_npc", bus.predict_npc, 32'h2000);
        look(32'h1000);
        check("alias_miss", {31'd0, bus.predict_taken}, 32'd0);
        step(0, 1, 1, 32'h1000, 0, 0, 0, 32'h1000);
        look(32'h1100);
        check("evict_taken", {31'd0, bus.predict_taken}, 32'd0);

        // Same-cycle read/write and stall
        step(0, 1, 1, 32'h1004, 1, 32'h3000, 0, 32'h1004);
        check("rw_same_cycle", {31'd0, obs_taken}, 32'd0);
        look(32'h1004);
        check("rw_next_cycle", {31'd0, bus.predict_taken}, 32'd1);
        step(0, 0, 1, 32'h1008, 1, 32'h4000, 1, 32'h1008);
        look(32'h1008);
        check("stall_taken", {31'd0, bus.predict_taken}, 32'd0);
        check("stall_br", bus.stat_branches, 32'd13);
        check("stall_mis", bus.stat_mispredicts, 32'd2);

        // Statistics wrap
        @(negedge clk_in);
        force dut.r_stat_branches = 32'hFFFF_FFFF;
        #1;
        release dut.r_stat_branches;
        m_br = 32'hFFFF_FFFF;
        step(0, 1, 1, 32'h1004, 1, 32'h3000, 0, 32'h1004);
        look(32'h1004);
        check("wrap_br", bus.stat_branches, 32'd0);

        // Reset with a simultaneous update
        step(1, 1, 1, 32'h1004, 1, 32'h3000, 1, 32'h1004);
        look(32'h1004);
        check("midrst_taken", {31'd0, bus.predict_taken}, 32'd0);
        check("midrst_br", bus.stat_branches, 32'd0);

        // Random traffic over a small PC pool to force aliasing
        for (int n = 0; n < 600; n++) begin
            upc = (tags[$urandom_range(0, 2)] << (IDX_W + 2)) |
                  (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            lpc = (tags[$urandom_range(0, 2)] << (IDX_W + 2)) |
                  (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 6), upc, 1'($urandom()), $urandom(),
                 1'($urandom()), lpc);
        end
        look(32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor serving the IF stage. It looks up the fetch PC and returns a taken/not-taken prediction and the next PC.
- It learns from the branch-resolution bundle produced by the EX stage: predict_update, actual_result, branch_npc1, branch_pc and predict_error.
- Structure: a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB).
- It also keeps free-running branch and mispredict statistics counters.

Parameters:
- IDX_W, 6: index width. Table depth is 2^IDX_W entries; index = pc[IDX_W+1:2].
- TAG_W, 24: tag width. Must equal 32-IDX_W-2; tag = pc[31:IDX_W+2].
- CNT_INIT, 2'b01: counter value loaded on reset (weakly not-taken).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset. Synchronous, active-high.
- rdy_in  input  1  global ready. When low, no table or statistics state changes.
- if_pc  input  32  fetch PC to predict
- predict_taken  output  1  prediction for if_pc (feeds EX predict_result via the pipeline)
- predict_npc  output  32  predicted next PC for if_pc
- upd_valid  input  1  resolved branch/jump present (EX predict_update)
- upd_pc  input  32  PC of the resolved instruction (EX branch_pc)
- upd_taken  input  1  actual outcome (EX actual_result)
- upd_target  input  32  actual next PC when taken (EX branch_npc1)
- upd_mispredict  input  1  EX predict_error; sampled only when upd_valid=1
- stat_branches  output  32  count of accepted updates
- stat_mispredicts  output  32  count of accepted updates with upd_mispredict=1

Behaviour:
- **Storage, per entry:**
  - cnt[1:0]
  - valid
  - tag[TAG_W-1:0]
  - target[31:0]
- **Reset:** on a clock edge with rst_in=1:
  - every cnt = CNT_INIT
  - every valid = 0
  - tag and target = 0
  - stat_branches = stat_mispredicts = 0
  - Reset overrides rdy_in and any simultaneous update. Reset mid-stream discards all learned state.
- **Lookup (combinational from registered tables, 0-cycle latency):**
  - i = if_pc[IDX_W+1:2]
  - hit = valid[i] && tag[i] == if_pc[31:IDX_W+2]
  - predict_taken = hit && cnt[i][1]
  - predict_npc = predict_taken ? target[i] : if_pc + 4 (32-bit, wraps modulo 2^32)
  - Since tables reset to invalid, predict_taken=0 and predict_npc=if_pc+4 during and immediately after reset.
- **Update:** at a clock edge with upd_valid=1, rdy_in=1, rst_in=0, with j = upd_pc[IDX_W+1:2]:
  - If tag[j] matches upd_pc[31:IDX_W+2] or valid[j]=0:
    - upd_taken=1: cnt[j] = min(cnt[j]+1, 3)
    - upd_taken=0: cnt[j] = max(cnt[j]-1, 0)
  - If valid[j]=1 and the tag mismatches (alias):
    - entry is reallocated
    - cnt[j] = upd_taken ? 2'b10 : 2'b01
  - When upd_taken=1: valid[j]=1, tag[j]=upd_pc tag, target[j]=upd_target.
  - When upd_taken=0 on a mismatching entry: valid[j]=0, so a not-taken alias evicts the entry.
  - upd_pc[1:0] is ignored.
- **Update visibility:** effect is visible to lookup starting the cycle after the edge. No write-to-read bypass: a same-cycle lookup of index j sees pre-update contents.
- **Statistics:**
  - stat_branches += 1 per accepted update.
  - stat_mispredicts += 1 when the accepted update also has upd_mispredict=1.
  - Both wrap 0xFFFFFFFF → 0.
  - Both are frozen when rdy_in=0.
- **rdy_in=0:** updates are dropped (not queued). Lookup still operates.
- **Jumps:** JAL/JALR arrive as upd_taken=1 and train identically to branches.

Test Plan:
1. **Reset defaults:** assert rst_in for 2 cycles, drive if_pc=0x1000 → predict_taken=0, predict_npc=0x1004, both stats=0.
2. **Training:** two updates {upd_pc=0x1000, taken=1, target=0x0F00, mispredict=1} → after the 1st, cnt=2, if_pc=0x1000 gives taken=1, npc=0x0F00. After the 2nd, cnt=3, stat_branches=2, stat_mispredicts=2.
3. **Saturation/hysteresis:** from cnt=3 at 0x1000, apply 1 not-taken update → still taken (cnt=2). Apply a 2nd not-taken → predict_taken=0, npc=0x1004. Apply 3 more not-taken → cnt holds at 0.
4. **Alias:** with 0x1000 trained taken, update upd_pc=0x1100 (same index 0, different tag) taken, target=0x2000:
   - if_pc=0x1100 → taken, npc=0x2000
   - if_pc=0x1000 → taken=0 (tag miss)
   - then a not-taken update at 0x1000 → entry invalid, if_pc=0x1100 predicts not-taken
5. **Same-cycle read/write and rdy_in:** update 0x1004 taken while if_pc=0x1004 → that cycle taken=0, next cycle taken=1. Repeat the update at 0x1008 with rdy_in=0 → no change, stats unchanged.
6. **Reset mid-operation and wrap:**
   - force stat_branches to 0xFFFFFFFF, accept 1 update → 0
   - assert rst_in together with upd_valid → tables cleared, update discarded, 0x1004 predicts not-taken
